// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounces one raw push-button pin. The pin passes through a
//               two-flop synchroniser. A four-state FSM accepts a new level
//               only after STABLE_TICKS consecutive agreeing samples, taken on
//               clocks where en_i is high. The result is a registered,
//               glitch-free level that a downstream rising-edge detector can
//               turn into a one-clock press pulse.
// Ports       : clk_i  - system clock, all flops on posedge
//               rst_ni - asynchronous active-low reset (0 = reset)
//               en_i   - sample strobe, 1-clk pulse from the clock divider
//               btn_i  - raw asynchronous bouncy pin (1 = pressed)
//               db_o   - debounced level, registered
// Parameters  : STABLE_TICKS - consecutive en samples needed to accept a level
//               CNT_W        - sample counter width
//                              (2 <= STABLE_TICKS <= 2**CNT_W-1)
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int unsigned STABLE_TICKS = 20,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic btn_i,
    output logic db_o
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             s0_q;
    logic             s1_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;

    // Two-flop synchroniser, free running: it is not gated by en_i so the
    // synchronised level is always fresh when a strobe arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= btn_i;
            s1_q <= s0_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOW;
            cnt_q   <= CNT_ZERO;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // cnt holds the number of consecutive samples already seen at the
    // candidate level, so the sample that finds cnt == STABLE_TICKS-1 is the
    // STABLE_TICKS-th one and commits the new level. Any disagreeing sample
    // drops back to the committed state with the count cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            LOW: begin
                if (en_i && s1_q) begin
                    state_d = RISE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (en_i) begin
                    if (!s1_q) begin
                        state_d = LOW;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ZERO;
                        db_d    = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            HIGH: begin
                if (en_i && !s1_q) begin
                    state_d = FALL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (en_i) begin
                    if (s1_q) begin
                        state_d = HIGH;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                        cnt_d   = CNT_ZERO;
                        db_d    = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            // Recovery from a corrupted state register does not wait for a
            // strobe.
            default: begin
                state_d = LOW;
                cnt_d   = CNT_ZERO;
                db_d    = 1'b0;
            end
        endcase
    end

    assign db_o = db_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (STABLE_TICKS = 4).
//               A behavioural model tracks the pin delayed by two clocks and
//               flips its level once four consecutive strobed samples disagree
//               with it. Directed scenarios with literal expectations are
//               followed by randomized bouncing stimulus with random strobe
//               patterns and asynchronous resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int ST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic btn   = 1'b0;
    logic db_o;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_rise = 0;

    // Behavioural model state
    logic m_p1  = 1'b0;   // pin one clock ago
    logic m_p2  = 1'b0;   // pin two clocks ago (what the FSM sees)
    logic m_db  = 1'b0;
    int   m_run = 0;      // consecutive strobed samples disagreeing with m_db

    button_debouncer #(
        .STABLE_TICKS (ST),
        .CNT_W        (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .btn_i  (btn),
        .db_o   (db_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: a level is accepted after ST consecutive strobed
    // samples of the delayed pin that disagree with the current level.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_p1  = 1'b0;
                m_p2  = 1'b0;
                m_db  = 1'b0;
                m_run = 0;
            end else begin
                if (en) begin
                    if (m_p2 != m_db) begin
                        m_run++;
                        if (m_run == ST) begin
                            m_db  = ~m_db;
                            m_run = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                m_p2 = m_p1;
                m_p1 = btn;
            end
        end
    end

    // Stands in for the downstream rising-edge detector.
    initial forever begin
        @(posedge db_o);
        n_rise++;
    end

    // Continuous comparison against the model.
    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            check("model_db", db_o, m_db);
        end
    end

    // One strobe period: pin set to b, en high on the 4th clock. Returns at
    // the negedge right after the strobed edge.
    task automatic strobe(input logic b);
        @(negedge clk);
        btn = b;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    // Literal expectation on both the DUT and the model.
    task automatic lit(input string name, input logic exp);
        check(name, db_o, exp);
        check({name, "_model"}, m_db, exp);
    endtask

    initial begin : driver
        int r0;
        int ph;
        int mode;
        int len;
        logic lvl;

        // 1: reset with pin high, then release
        btn = 1'b1;
        repeat (3) @(negedge clk);
        lit("t1_reset_db", 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b1);
            lit("t1_rise", (i == ST));
        end

        // 2: clean release then clean press
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b0);
            lit("t2_release", (i != ST));
        end
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b1);
            lit("t2_press", (i == ST));
        end
        for (int i = 1; i <= ST; i++) strobe(1'b0);
        lit("t2_back_low", 1'b0);

        // 3: press bounce, three ones, one zero, then steady ones
        r0 = n_rise;
        for (int i = 0; i < 3; i++) strobe(1'b1);
        lit("t3_after3", 1'b0);
        strobe(1'b0);
        lit("t3_bounce", 1'b0);
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b1);
            lit("t3_fresh", (i == ST));
        end
        check("t3_one_rise", ((n_rise - r0) == 1), 1'b1);

        // 4: release bounce from HIGH
        strobe(1'b0);
        strobe(1'b0);
        lit("t4_fall_chk", 1'b1);
        for (int i = 0; i < 6; i++) strobe(1'b1);
        lit("t4_held_high", 1'b1);
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b0);
            lit("t4_release", (i != ST));
        end

        // 5: qualification frozen while en stays low
        strobe(1'b1);
        strobe(1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            en  = 1'b0;
            btn = 1'($urandom_range(0, 1));
        end
        lit("t5_frozen", 1'b0);
        strobe(1'b1);
        lit("t5_resume1", 1'b0);
        strobe(1'b1);
        lit("t5_resume2", 1'b1);
        for (int i = 0; i < ST; i++) strobe(1'b0);

        // 6: async reset mid-qualification, then from HIGH
        r0 = n_rise;
        strobe(1'b1);
        strobe(1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 lit("t6_rst_in_rise", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_no_pulse", (n_rise == r0), 1'b1);
        for (int i = 1; i <= ST; i++) begin
            strobe(1'b1);
            lit("t6_requalify", (i == ST));
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 lit("t6_rst_from_high", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized bouncing pin with mixed strobe patterns.
        ph = 0;
        for (int seg = 0; seg < 60; seg++) begin
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(5, 60));
            lvl  = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                case (mode)
                    0:       en = ((ph % 4) == 3);
                    1:       en = 1'b1;
                    default: en = ($urandom_range(0, 2) == 0);
                endcase
                ph++;
                btn = ($urandom_range(0, 9) == 0) ? ~lvl : lvl;
            end
            if ($urandom_range(0, 9) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_async_rst", db_o, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
